mdu_seq: RTL and testbench

Multi-cycle RV32M multiply/divide sequencer for the RV32 ALU. It runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU as a fixed sequence of shift/add or shift/subtract steps. The steps use the ALU's single 32-bit carry-lookahead adder, so no second carry chain is needed. While busy, the block owns the adder through a request line; otherwise the ALU's normal operand mux drives the adder.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_mdu_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the RV32M multiply/divide sequencer.
// Rev 1.0
`default_nettype none

package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP_A = 3'd1,
    S_PREP_B = 3'd2,
    S_LOOP   = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M MUL*/DIV*/REM* sequencer borrowing the ALU's shared adder.
// Rev 1.0
`default_nettype none

module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            add_req,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  output logic            add_cin,
  input  logic [XLEN-1:0] add_sum,
  input  logic            add_cout
);

  localparam logic [4:0]      LAST_ITER = 5'(ITER - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0] am_q, am_d, bm_q, bm_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            in_sa, in_sb, in_dz, in_ovf, in_rem;
  logic            is_div, is_rem, neg;
  logic            div_ov;
  logic [XLEN-1:0] sh_hi, sh_lo;
  logic            mul_c;
  logic [XLEN-1:0] mul_h;

  assign in_sa  = (op == MDU_MUL) | (op == MDU_MULH) | (op == MDU_MULHSU)
                | (op == MDU_DIV) | (op == MDU_REM);
  assign in_sb  = (op == MDU_MULH) | (op == MDU_DIV) | (op == MDU_REM);
  assign in_rem = op[2] & op[1];
  assign in_dz  = op[2] & (b == '0);
  assign in_ovf = ((op == MDU_DIV) | (op == MDU_REM)) & (a == INT_MIN) & (b == '1);

  assign is_div = op_q[2];
  assign is_rem = op_q[2] & op_q[1];
  // REM negates by the dividend sign only; quotient and product by sa ^ sb.
  assign neg    = is_rem ? sa_q : (sa_q ^ sb_q);

  assign div_ov = hi_q[XLEN-1];
  assign sh_hi  = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  assign sh_lo  = {lo_q[XLEN-2:0], 1'b0};
  assign mul_c  = lo_q[0] & add_cout;
  assign mul_h  = lo_q[0] ? add_sum : hi_q;

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign add_req = busy;
  assign done    = (state_q == S_DONE);
  assign result  = result_q;

  // Adder operands depend on registered state only, keeping the loop one adder deep.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      S_PREP_A: begin
        add_a   = sa_q ? ~am_q : am_q;
        add_cin = sa_q;
      end
      S_PREP_B: begin
        add_a   = sb_q ? ~bm_q : bm_q;
        add_cin = sb_q;
      end
      S_LOOP: begin
        if (is_div) begin
          add_a   = sh_hi;
          add_b   = ~bm_q;
          add_cin = 1'b1;
        end else begin
          add_a   = hi_q;
          add_b   = am_q;
        end
      end
      S_FIX_LO: begin
        add_a   = is_rem ? (neg ? ~hi_q : hi_q) : (neg ? ~lo_q : lo_q);
        add_cin = neg;
      end
      S_FIX_HI: begin
        if (is_div) begin
          add_a   = hi_q;
        end else begin
          add_a   = neg ? ~hi_q : hi_q;
          add_cin = neg & carry_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    am_d     = am_q;
    bm_d     = bm_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          sa_d  = in_sa & a[XLEN-1];
          sb_d  = in_sb & b[XLEN-1];
          am_d  = a;
          bm_d  = b;
          hi_d  = '0;
          lo_d  = '0;
          cnt_d = '0;
          if (in_dz) begin
            result_d = in_rem ? a : '1;
            state_d  = S_DONE;
          end else if (in_ovf) begin
            result_d = in_rem ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else begin
            state_d  = S_PREP_A;
          end
        end
      end
      S_PREP_A: begin
        am_d    = add_sum;
        state_d = S_PREP_B;
      end
      S_PREP_B: begin
        bm_d    = add_sum;
        hi_d    = '0;
        lo_d    = is_div ? am_q : add_sum;
        cnt_d   = '0;
        state_d = S_LOOP;
      end
      S_LOOP: begin
        if (is_div) begin
          // Restoring step: the bit shifted out of hi forces acceptance.
          if (div_ov | add_cout) begin
            hi_d = add_sum;
            lo_d = sh_lo | {{(XLEN-1){1'b0}}, 1'b1};
          end else begin
            hi_d = sh_hi;
            lo_d = sh_lo;
          end
        end else begin
          hi_d = {mul_c, mul_h[XLEN-1:1]};
          lo_d = {mul_h[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) state_d = S_FIX_LO;
      end
      S_FIX_LO: begin
        if (is_rem) begin
          hi_d = add_sum;
        end else begin
          lo_d    = add_sum;
          carry_d = add_cout;
        end
        state_d = S_FIX_HI;
      end
      S_FIX_HI: begin
        hi_d = add_sum;
        if (is_div) result_d = is_rem ? add_sum : lo_q;
        else        result_d = (op_q == MDU_MUL) ? lo_q : add_sum;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      am_q     <= '0;
      bm_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      am_q     <= am_d;
      bm_q     <= bm_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq with a behavioural shared adder.
// Rev 1.0
`default_nettype none

module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, add_req, add_cin, add_cout;
  logic [31:0] result, add_a, add_b, add_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = 33'(add_a) + 33'(add_b) + 33'(add_cin);

  mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .add_req(add_req),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res,
                       input int exp_lat, input logic with_kill);
    int cyc;
    logic bad;
    start = 1'b1; kill = with_kill; op = o; a = x; b = y;
    step();
    start = 1'b0; kill = 1'b0;
    cyc = 1;
    bad = 1'b0;
    while (cyc < 80) begin
      if ((busy !== (cyc < exp_lat)) || (add_req !== busy)) bad = 1'b1;
      if (done === 1'b1) break;
      step();
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_busy"}, {31'b0, bad}, 32'd0);
    step();
    check({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic saw_done;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) step();
    check("rst_busy",   {31'b0, busy},    32'd0);
    check("rst_done",   {31'b0, done},    32'd0);
    check("rst_result", result,           32'd0);
    check("rst_addreq", {31'b0, add_req}, 32'd0);
    check("rst_adda",   add_a,            32'd0);
    check("rst_addb",   add_b,            32'd0);
    check("rst_cin",    {31'b0, add_cin}, 32'd0);
    rst_n = 1'b1;
    step();

    do_op("mulhu_ff",  MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 37, 1'b0);
    do_op("mul_m3x7",  MDU_MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 37, 1'b0);
    do_op("mulh_m3x7", MDU_MULH,   32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 37, 1'b0);
    do_op("mulhsu",    MDU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 37, 1'b0);
    do_op("mulhu_big", MDU_MULHU,  32'h8000_0000, 32'd4,         32'd2,         37, 1'b0);
    do_op("div_m7_2",  MDU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 37, 1'b0);
    do_op("rem_m7_2",  MDU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 37, 1'b0);
    do_op("divu_ov",   MDU_DIVU,   32'h8000_0001, 32'h8000_0000, 32'd1,         37, 1'b0);
    do_op("remu_ov",   MDU_REMU,   32'h8000_0001, 32'h8000_0000, 32'd1,         37, 1'b0);
    do_op("div_100_m7", MDU_DIV,   32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 37, 1'b0);
    do_op("rem_100_m7", MDU_REM,   32'd100,       32'hFFFF_FFF9, 32'd2,         37, 1'b0);
    do_op("divu_dz",   MDU_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1,  1'b0);
    do_op("remu_dz",   MDU_REMU,   32'h0000_1234, 32'd0,         32'h0000_1234, 1,  1'b0);
    do_op("div_ovf",   MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
    do_op("rem_ovf",   MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0);
    do_op("div_dz_m5", MDU_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1,  1'b0);
    do_op("rem_dz_m5", MDU_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1,  1'b0);
    do_op("start_kill", MDU_MUL,   32'd6,         32'd7,         32'd42,        37, 1'b1);

    // Kill in cycle 10 with an ignored start in cycle 5.
    start = 1'b1; op = MDU_MUL; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      if (c == 5) begin start = 1'b1; op = MDU_DIVU; a = 32'd5; b = 32'd0; end
      if (c == 6) begin
        start = 1'b0;
        check("ign_start_busy", {31'b0, busy}, 32'd1);
      end
      if (c == 10) kill = 1'b1;
      step();
    end
    kill = 1'b0;
    if (done === 1'b1) saw_done = 1'b1;
    check("kill_busy",   {31'b0, busy},     32'd0);
    check("kill_nodone", {31'b0, saw_done}, 32'd0);
    check("kill_result", result,            32'd42);
    do_op("after_kill", MDU_MUL, 32'd6, 32'd8, 32'd48, 37, 1'b0);

    // Reset pulse in cycle 20 of a running op, with start held during reset.
    start = 1'b1; op = MDU_MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    repeat (19) step();
    rst_n = 1'b0; start = 1'b1; kill = 1'b1;
    step();
    rst_n = 1'b1; start = 1'b0; kill = 1'b0;
    check("mid_rst_busy",   {31'b0, busy},    32'd0);
    check("mid_rst_done",   {31'b0, done},    32'd0);
    check("mid_rst_result", result,           32'd0);
    check("mid_rst_adda",   add_a,            32'd0);
    check("mid_rst_addb",   add_b,            32'd0);
    check("mid_rst_cin",    {31'b0, add_cin}, 32'd0);
    step();
    check("post_rst_idle",  {31'b0, busy},    32'd0);
    do_op("after_rst", MDU_DIVU, 32'd100, 32'd7, 32'd14, 37, 1'b0);
    do_op("remu_100_7", MDU_REMU, 32'd100, 32'd7, 32'd2, 37, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
